// File: rtl/panel_write_arbiter.sv
// panel_write_arbiter
//   Round-robin arbiter that shares the single panel write bus between
//   NUM_REQ pixel sources. A grant is locked for a burst until 'last' (or
//   until MAX_BURST beats). Beats with an out-of-range panel or address are
//   accepted but discarded. On every cycle without a written beat, ctrl_en
//   sits at IDLE_EN so that no panel is selected.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no lock; round-robin search from rr_ptr each cycle
//   S_BURST | bus locked to owner_q until its last beat or MAX_BURST beats
//
// Ports
//   display_clock  in   clock, rising edge
//   reset          in   synchronous, active-high
//   req_valid      in   [NUM_REQ]     beat offered by requester i
//   req_ready      out  [NUM_REQ]     beat accepted this cycle (comb, one-hot/zero)
//   req_last       in   [NUM_REQ]     final beat of a burst
//   req_panel      in   [8*NUM_REQ]   panel index per requester
//   req_addr       in   [16*NUM_REQ]  pixel address per requester
//   req_wdat       in   [16*NUM_REQ]  RGB565 pixel per requester
//   ctrl_en        out  [8]           panel select, IDLE_EN when no write
//   ctrl_addr      out  [16]          write address
//   ctrl_wdat      out  [16]          write data
//   grant_id       out  [2]           current or most recent bus owner
//   busy           out                high in S_BURST
//   drop_pulse     out                accepted beat was discarded (range)
//   burst_err      out                burst force-released at MAX_BURST
module panel_write_arbiter #(
  parameter int          NUM_REQ    = 2,
  parameter int          NUM_PANELS = 8,
  parameter int          PIXELS     = 4096,
  parameter int          MAX_BURST  = 4096,
  parameter logic [7:0]  IDLE_EN    = 8'hFF
) (
  input  logic                    display_clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [8*NUM_REQ-1:0]    req_panel,
  input  logic [16*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]   req_wdat,
  output logic [7:0]              ctrl_en,
  output logic [15:0]             ctrl_addr,
  output logic [15:0]             ctrl_wdat,
  output logic [1:0]              grant_id,
  output logic                    busy,
  output logic                    drop_pulse,
  output logic                    burst_err
);

  localparam int               CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]    MAX_CNT   = CW'(MAX_BURST);
  localparam logic [8:0]       PANEL_LIM = 9'(NUM_PANELS);
  localparam logic [16:0]      PIX_LIM   = 17'(PIXELS);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]   cnt_inc;

  logic            found;
  logic            acc;
  logic [1:0]      acc_id;
  logic            acc_last;
  logic [7:0]      acc_panel;
  logic [15:0]     acc_addr;
  logic [15:0]     acc_wdat;
  logic            in_range;
  logic            force_rel;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return 2'((int'(id) + 1) % NUM_REQ);
  endfunction

  // Winner selection and payload mux. In IDLE the search walks from rr_ptr
  // upward (mod NUM_REQ); in BURST only the owner is eligible.
  always_comb begin
    found     = 1'b0;
    acc_id    = 2'd0;
    acc_last  = 1'b0;
    acc_panel = 8'd0;
    acc_addr  = 16'd0;
    acc_wdat  = 16'd0;
    req_ready = '0;
    if (state_q == S_IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && (i == (int'(rr_ptr_q) + k) % NUM_REQ) && req_valid[i]) begin
            found  = 1'b1;
            acc_id = 2'(i);
          end
        end
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((i == int'(owner_q)) && req_valid[i]) begin
          found  = 1'b1;
          acc_id = 2'(i);
        end
      end
    end
    // Nothing is accepted on a reset cycle; the beat stays with its source.
    acc = found && !reset;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == int'(acc_id)) begin
        acc_last     = req_last[i];
        acc_panel    = req_panel[8*i +: 8];
        acc_addr     = req_addr[16*i +: 16];
        acc_wdat     = req_wdat[16*i +: 16];
        req_ready[i] = acc;
      end
    end
  end

  assign in_range = ({1'b0, acc_panel} < PANEL_LIM) &&
                    (acc_panel != IDLE_EN) &&
                    ({1'b0, acc_addr} < PIX_LIM);

  assign cnt_inc = beat_cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_id;
    force_rel  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          grant_d  = acc_id;
          rr_ptr_d = next_id(acc_id);
          if (!acc_last) begin
            state_d    = S_BURST;
            owner_d    = acc_id;
            beat_cnt_d = CW'(1);
          end
        end
      end
      S_BURST: begin
        if (acc) begin
          beat_cnt_d = cnt_inc;
          if (acc_last) begin
            state_d    = S_IDLE;
            rr_ptr_d   = next_id(owner_q);
            beat_cnt_d = '0;
          end else if (cnt_inc == MAX_CNT) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            force_rel  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge display_clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
      beat_cnt_q <= '0;
      grant_id   <= 2'd0;
      ctrl_en    <= IDLE_EN;
      ctrl_addr  <= 16'd0;
      ctrl_wdat  <= 16'd0;
      drop_pulse <= 1'b0;
      burst_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      grant_id   <= grant_d;
      ctrl_en    <= (acc && in_range) ? acc_panel : IDLE_EN;
      if (acc && in_range) begin
        ctrl_addr <= acc_addr;
        ctrl_wdat <= acc_wdat;
      end
      drop_pulse <= acc && !in_range;
      burst_err  <= force_rel;
    end
  end

  assign busy = (state_q == S_BURST);

endmodule

// File: tb/tb_panel_write_arbiter.sv
// Randomized bench for panel_write_arbiter with a behavioural reference model.
module tb_panel_write_arbiter;

  localparam int NR   = 3;
  localparam int MAXB = 16;

  logic                 display_clock = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        req_last;
  logic [8*NR-1:0]      req_panel;
  logic [16*NR-1:0]     req_addr;
  logic [16*NR-1:0]     req_wdat;
  logic [7:0]           ctrl_en;
  logic [15:0]          ctrl_addr;
  logic [15:0]          ctrl_wdat;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 drop_pulse;
  logic                 burst_err;

  panel_write_arbiter #(
    .NUM_REQ(NR), .NUM_PANELS(8), .PIXELS(4096), .MAX_BURST(MAXB), .IDLE_EN(8'hFF)
  ) dut (
    .display_clock(display_clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_panel(req_panel), .req_addr(req_addr), .req_wdat(req_wdat),
    .ctrl_en(ctrl_en), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .grant_id(grant_id), .busy(busy), .drop_pulse(drop_pulse), .burst_err(burst_err)
  );

  always #5 display_clock = ~display_clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_burst = 0;
  int          m_owner = 0;
  int          m_ptr   = 0;
  int          m_cnt   = 0;
  logic [7:0]  e_en    = 8'hFF;
  logic [15:0] e_addr  = 0;
  logic [15:0] e_wdat  = 0;
  logic [1:0]  e_grant = 0;
  bit          e_drop  = 0;
  bit          e_err   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int p_valid, input int p_last, input bit rst);
    int r;
    reset = rst;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = ($urandom_range(99) < p_valid);
      req_last[i]  = ($urandom_range(99) < p_last);
      r = $urandom_range(99);
      if (r < 85)      req_panel[8*i +: 8] = 8'($urandom_range(7));
      else if (r < 93) req_panel[8*i +: 8] = 8'($urandom_range(254, 8));
      else             req_panel[8*i +: 8] = 8'hFF;
      if ($urandom_range(99) < 90) req_addr[16*i +: 16] = 16'($urandom_range(4095));
      else                         req_addr[16*i +: 16] = 16'($urandom_range(65535, 4096));
      req_wdat[16*i +: 16] = 16'($urandom);
    end
  endtask

  // One clock: check comb ready, advance the model, check registered outputs.
  task automatic step();
    int          w;
    logic [NR-1:0] exp_ready;
    logic [7:0]  pan;
    logic [15:0] adr;
    bit          lst;
    #1;
    w = -1;
    if (!reset) begin
      if (!m_burst) begin
        for (int k = 0; k < NR; k++)
          if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      end else if (req_valid[m_owner]) begin
        w = m_owner;
      end
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));

    if (reset) begin
      m_burst = 0; m_ptr = 0; m_cnt = 0; m_owner = 0;
      e_en = 8'hFF; e_addr = 0; e_wdat = 0; e_grant = 0; e_drop = 0; e_err = 0;
    end else begin
      e_drop = 0; e_err = 0; e_en = 8'hFF;
      if (w >= 0) begin
        pan = req_panel[8*w +: 8];
        adr = req_addr[16*w +: 16];
        lst = req_last[w];
        if (pan < 8 && adr < 4096) begin
          e_en = pan; e_addr = adr; e_wdat = req_wdat[16*w +: 16];
        end else begin
          e_drop = 1;
        end
        if (!m_burst) begin
          e_grant = 2'(w);
          m_ptr = (w + 1) % NR;
          if (!lst) begin m_burst = 1; m_owner = w; m_cnt = 1; end
        end else begin
          m_cnt++;
          if (lst) begin
            m_burst = 0; m_ptr = (m_owner + 1) % NR;
          end else if (m_cnt == MAXB) begin
            m_burst = 0; e_err = 1;
          end
        end
      end
    end

    @(posedge display_clock);
    #1;
    check_val("ctrl_en",    32'(ctrl_en),    32'(e_en));
    check_val("ctrl_addr",  32'(ctrl_addr),  32'(e_addr));
    check_val("ctrl_wdat",  32'(ctrl_wdat),  32'(e_wdat));
    check_val("grant_id",   32'(grant_id),   32'(e_grant));
    check_val("busy",       32'(busy),       32'(m_burst));
    check_val("drop_pulse", 32'(drop_pulse), 32'(e_drop));
    check_val("burst_err",  32'(burst_err),  32'(e_err));
  endtask

  int ph_valid [5] = '{100, 90, 60, 95, 40};
  int ph_last  [5] = '{100, 30, 10, 0, 50};
  int ph_len   [5] = '{40, 600, 600, 300, 500};

  initial begin
    reset = 1'b1; req_valid = '0; req_last = '0;
    req_panel = '0; req_addr = '0; req_wdat = '0;
    // reset held 3 clocks with every source valid
    for (int c = 0; c < 3; c++) begin
      drive(100, 100, 1'b1);
      step();
    end
    for (int ph = 0; ph < 5; ph++) begin
      for (int c = 0; c < ph_len[ph]; c++) begin
        drive(ph_valid[ph], ph_last[ph], (ph > 0) && ($urandom_range(299) == 0));
        step();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
